// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART types and line constants (transmitter and receiver).
// Revision    : 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int   DATA_W     = 8;
    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    function automatic logic even_parity(input logic [DATA_W-1:0] b);
        return ^b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_baud_gen.sv
// ============================================================================
// Module      : uart_baud_gen
// Description : Clocks-per-bit down-counter; bit_tick marks the last cycle of a
//               bit period. restart begins a fresh full period.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic bit_tick
);

    localparam int              CNT_W  = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (restart || (cnt_q == '0)) begin
            cnt_d = RELOAD;
        end else begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // With CLKS_PER_BIT=1 the counter sits at zero, so every cycle ticks.
    assign bit_tick = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/uart_transmitter.sv
// ============================================================================
// Module      : uart_transmitter
// Description : 8N/8E UART serialiser with valid/ready input handshake.
//               Build option UART_TX_PARITY_EN adds an even-parity bit.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module uart_transmitter
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter int STOP_BITS    = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DATA_W-1:0]   data,
    input  logic                valid,
    output logic                ready,
    output logic                serial,
    output logic                busy
);

    localparam logic [2:0] LAST_DATA = 3'(DATA_W - 1);
    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

    tx_state_t          state_q,   state_d;
    logic [2:0]         bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]  shift_q,   shift_d;
    logic               serial_q,  serial_d;
    logic               accept;
    logic               baud_restart;
    logic               bit_tick;

`ifdef UART_TX_PARITY_EN
    logic               parity_q,  parity_d;
`endif

    assign ready  = (state_q == IDLE);
    assign busy   = ~ready;
    assign serial = serial_q;
    assign accept = valid && ready;

    uart_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_gen (
        .clk      (clk),
        .rst      (rst),
        .restart  (baud_restart),
        .bit_tick (bit_tick)
    );

`ifdef UART_TX_PARITY_EN
    // Parity is captured from the accepted byte since the shifter consumes it.
    always_comb begin
        parity_d = parity_q;
        if (accept) begin
            parity_d = even_parity(data);
        end
    end
`endif

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        serial_d     = serial_q;
        baud_restart = 1'b0;

        case (state_q)
            IDLE: begin
                serial_d = LINE_IDLE;
                if (accept) begin
                    state_d      = START;
                    shift_d      = data;
                    serial_d     = LINE_START;
                    bit_cnt_d    = '0;
                    baud_restart = 1'b1;
                end
            end

            START: begin
                if (bit_tick) begin
                    state_d  = DATA;
                    serial_d = shift_q[0];
                    shift_d  = {1'b0, shift_q[DATA_W-1:1]};
                end
            end

            DATA: begin
                if (bit_tick) begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == LAST_DATA) begin
`ifdef UART_TX_PARITY_EN
                        state_d  = PARITY;
                        serial_d = parity_q;
`else
                        state_d  = STOP;
                        serial_d = LINE_IDLE;
`endif
                    end else begin
                        serial_d = shift_q[0];
                        shift_d  = {1'b0, shift_q[DATA_W-1:1]};
                    end
                end
            end

`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_tick) begin
                    state_d  = STOP;
                    serial_d = LINE_IDLE;
                end
            end
`endif

            STOP: begin
                serial_d = LINE_IDLE;
                if (bit_tick) begin
                    if (bit_cnt_q == LAST_STOP) begin
                        state_d   = IDLE;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end

            default: begin
                state_d  = IDLE;
                serial_d = LINE_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            serial_q  <= LINE_IDLE;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            serial_q  <= serial_d;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_transmitter.sv
// ============================================================================
// Module      : tb_uart_transmitter
// Description : Self-checking bench for uart_transmitter (CLKS_PER_BIT=4/STOP=2
//               and CLKS_PER_BIT=1/STOP=1 instances). Honours UART_TX_PARITY_EN.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_uart_transmitter;

`ifdef UART_TX_PARITY_EN
    localparam int FRAME_A = 48;
`else
    localparam int FRAME_A = 44;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_a, data_b;
    logic       valid_a, valid_b;
    logic       ready_a, serial_a, busy_a;
    logic       ready_b, serial_b, busy_b;

    always #5 clk = ~clk;

    uart_transmitter #(.CLKS_PER_BIT(4), .STOP_BITS(2)) dut_a (
        .clk(clk), .rst(rst), .data(data_a), .valid(valid_a),
        .ready(ready_a), .serial(serial_a), .busy(busy_a)
    );

    uart_transmitter #(.CLKS_PER_BIT(1), .STOP_BITS(1)) dut_b (
        .clk(clk), .rst(rst), .data(data_b), .valid(valid_b),
        .ready(ready_b), .serial(serial_b), .busy(busy_b)
    );

    typedef struct {
        logic ser;
        logic rdy;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        logic       par;
    } vec_t;

    exp_t q_a[$];
    exp_t q_b[$];
    vec_t tbl[8];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic checkn(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic push_n(input bit sel_b, input logic ser, input logic rdy, input int n);
        exp_t e;
        e.ser = ser;
        e.rdy = rdy;
        for (int k = 0; k < n; k++) begin
            if (sel_b) q_b.push_back(e);
            else       q_a.push_back(e);
        end
    endtask

    // Reference line waveform, one entry per clock: start, data LSB first,
    // optional parity, stop bits.
    task automatic push_frame(input bit sel_b, input logic [7:0] b, input logic par);
        int cpb;
        int st;
        cpb = sel_b ? 1 : 4;
        st  = sel_b ? 1 : 2;
        push_n(sel_b, 1'b0, 1'b0, cpb);
        for (int i = 0; i < 8; i++) push_n(sel_b, b[i], 1'b0, cpb);
`ifdef UART_TX_PARITY_EN
        push_n(sel_b, par, 1'b0, cpb);
`endif
        push_n(sel_b, 1'b1, 1'b0, cpb * st);
    endtask

    task automatic wait_ready(input bit sel_b);
        int k;
        k = 0;
        while (!(sel_b ? ready_b : ready_a) && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!(sel_b ? ready_b : ready_a)) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_ready: ready stayed %b for %0d cycles, required 1",
                     sel_b ? ready_b : ready_a, k);
        end
    endtask

    task automatic drain(input bit sel_b, input bit glitch);
        exp_t e;
        int   i;
        i = 0;
        while ((sel_b ? q_b.size() : q_a.size()) > 0) begin
            @(negedge clk);
            if (sel_b) begin
                e = q_b.pop_front();
                check1("serial_b", serial_b, e.ser);
                check1("ready_b", ready_b, e.rdy);
                valid_b = 1'b0;
                data_b  = 8'($urandom);
            end else begin
                e = q_a.pop_front();
                check1("serial_a", serial_a, e.ser);
                check1("ready_a", ready_a, e.rdy);
                check1("busy_a", busy_a, ~e.rdy);
                data_a  = 8'($urandom);
                valid_a = glitch && (i % 3 == 1) && (q_a.size() > 2);
            end
            i++;
        end
    endtask

    task automatic send(input bit sel_b, input logic [7:0] b, input logic par, input bit glitch);
        @(negedge clk);
        wait_ready(sel_b);
        if (sel_b) begin
            data_b  = b;
            valid_b = 1'b1;
        end else begin
            data_a  = b;
            valid_a = 1'b1;
        end
        push_frame(sel_b, b, par);
        push_n(sel_b, 1'b1, 1'b1, 2);
        drain(sel_b, glitch);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t       e;
        int         cnt;
        logic [10:0] seq_b;
        int         len_b;

        rst     = 1'b1;
        valid_a = 1'b0;
        valid_b = 1'b0;
        data_a  = 8'h00;
        data_b  = 8'h00;

        tbl[0] = '{8'hA5, 1'b0};
        tbl[1] = '{8'h07, 1'b1};
        tbl[2] = '{8'h00, 1'b0};
        tbl[3] = '{8'hFF, 1'b0};
        tbl[4] = '{8'h3C, 1'b0};
        tbl[5] = '{8'h81, 1'b0};
        tbl[6] = '{8'h01, 1'b1};
        tbl[7] = '{8'h80, 1'b1};

        #3;
        check1("rst serial_a", serial_a, 1'b1);
        check1("rst ready_a", ready_a, 1'b1);
        check1("rst busy_a", busy_a, 1'b0);
        check1("rst serial_b", serial_b, 1'b1);
        check1("rst ready_b", ready_b, 1'b1);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) send(1'b0, tbl[i].data, tbl[i].par, 1'b0);

        // Accept-to-ready latency for 0xA5
        @(negedge clk);
        wait_ready(1'b0);
        data_a  = 8'hA5;
        valid_a = 1'b1;
        cnt = 0;
        do begin
            @(negedge clk);
            valid_a = 1'b0;
            cnt++;
        end while (!ready_a && cnt < 200);
        checkn("frame_len_a", cnt - 1, FRAME_A);

        // Back-to-back with valid held: 0x00 then 0xFF
        @(negedge clk);
        wait_ready(1'b0);
        data_a  = 8'h00;
        valid_a = 1'b1;
        push_frame(1'b0, 8'h00, 1'b0);
        push_n(1'b0, 1'b1, 1'b1, 1);
        push_frame(1'b0, 8'hFF, 1'b0);
        push_n(1'b0, 1'b1, 1'b1, 2);
        cnt = 0;
        while (q_a.size() > 0) begin
            @(negedge clk);
            e = q_a.pop_front();
            check1("b2b serial_a", serial_a, e.ser);
            check1("b2b ready_a", ready_a, e.rdy);
            if (cnt == 0) data_a = 8'hFF;
            if (cnt == FRAME_A + 1) valid_a = 1'b0;
            cnt++;
        end

        // Data/valid churn during a frame must not disturb it
        send(1'b0, 8'hC3, 1'b0, 1'b1);

        // Reset in the middle of the third data bit
        @(negedge clk);
        wait_ready(1'b0);
        data_a  = 8'h5A;
        valid_a = 1'b1;
        push_frame(1'b0, 8'h5A, 1'b0);
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            e = q_a.pop_front();
            check1("pre-rst serial_a", serial_a, e.ser);
            valid_a = 1'b0;
        end
        #2 rst = 1'b1;
        #1;
        check1("async rst serial_a", serial_a, 1'b1);
        check1("async rst ready_a", ready_a, 1'b1);
        check1("async rst busy_a", busy_a, 1'b0);
        #1 rst = 1'b0;
        q_a.delete();
        push_n(1'b0, 1'b1, 1'b1, 3);
        drain(1'b0, 1'b0);
        send(1'b0, 8'h3C, 1'b0, 1'b0);

        // Single-clock bits, single stop bit
        send(1'b1, 8'h81, 1'b0, 1'b0);
        send(1'b1, 8'h07, 1'b1, 1'b0);

`ifdef UART_TX_PARITY_EN
        seq_b = 11'b10100000010;
        len_b = 11;
`else
        seq_b = 11'b01100000010;
        len_b = 10;
`endif
        @(negedge clk);
        wait_ready(1'b1);
        data_b  = 8'h81;
        valid_b = 1'b1;
        for (int i = 0; i < len_b; i++) begin
            @(negedge clk);
            valid_b = 1'b0;
            check1("lit serial_b", serial_b, seq_b[i]);
        end
        @(negedge clk);
        check1("lit ready_b", ready_b, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
